// File: rtl/alu_mdu_if.sv
// Request/result bundle between a requester and the alu_mdu execution unit.
interface alu_mdu_if #(
    parameter int unsigned XLEN = 32
);
    logic            START;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [4:0]      CTRL;
    logic [2:0]      BRANCHCONDITION;
    logic            BUSY;
    logic            DONE;
    logic [XLEN-1:0] OUT;
    logic            BRANCHFLAG;
    logic            ILLEGAL;

    modport master (
        output START, A, B, CTRL, BRANCHCONDITION,
        input  BUSY, DONE, OUT, BRANCHFLAG, ILLEGAL
    );

    modport slave (
        input  START, A, B, CTRL, BRANCHCONDITION,
        output BUSY, DONE, OUT, BRANCHFLAG, ILLEGAL
    );
endinterface

// File: rtl/alu_mdu.sv
// ALU with iterative multiply (shift-add) and optional restoring divide.
// Base ops complete in one cycle; MUL*/DIV*/REM* iterate XLEN cycles in RUN.
// Build macro ALU_MDU_DIV_EN: when defined the divider is present; when not,
// DIV/DIVU/REM/REMU are reported as illegal ops.
module alu_mdu #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic     CLK,
    input  logic     RESETN,
    alu_mdu_if.slave bus
);
    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned WW = 2 * XLEN + 1;

`ifdef ALU_MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [4:0] OP_ADD    = 5'b00000;
    localparam logic [4:0] OP_SUB    = 5'b00001;
    localparam logic [4:0] OP_SLL    = 5'b00010;
    localparam logic [4:0] OP_SRL    = 5'b00011;
    localparam logic [4:0] OP_SRA    = 5'b00100;
    localparam logic [4:0] OP_AND    = 5'b00101;
    localparam logic [4:0] OP_OR     = 5'b00110;
    localparam logic [4:0] OP_XOR    = 5'b00111;
    localparam logic [4:0] OP_SLT    = 5'b01000;
    localparam logic [4:0] OP_SLTU   = 5'b01001;
    localparam logic [4:0] OP_MUL    = 5'b10000;
    localparam logic [4:0] OP_MULH   = 5'b10001;
    localparam logic [4:0] OP_MULHSU = 5'b10010;
    localparam logic [4:0] OP_MULHU  = 5'b10011;
`ifdef ALU_MDU_DIV_EN
    localparam logic [4:0] OP_DIV    = 5'b10100;
    localparam logic [4:0] OP_DIVU   = 5'b10101;
    localparam logic [4:0] OP_REM    = 5'b10110;
    localparam logic [4:0] OP_REMU   = 5'b10111;
`endif

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] a_q, a_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [4:0]      ctrl_q, ctrl_d;
    logic [2:0]      bc_q, bc_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [WW-1:0]   work_q, work_d;
    logic            neg_q, neg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            bflag_q, bflag_d;
    logic            ill_q, ill_d;

    logic            accept;
    logic            req_legal;
    logic            req_mdu;
    logic            sign_a;
    logic            sign_b;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN:0]   mul_sum;
    logic [WW-1:0]   mul_step;
    logic [WW-1:0]   run_step;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] mdu_res;

    function automatic logic op_legal(input logic [4:0] c);
        logic ok;
        if (!c[4]) begin
            ok = (c[3:0] <= 4'd9);
        end else begin
            ok = !c[3] && (!c[2] || DIV_EN);
        end
        return ok;
    endfunction

    function automatic logic [XLEN-1:0] base_result(input logic [4:0] c,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        case (c)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SLL:  r = a << sh;
            OP_SRL:  r = a >> sh;
            OP_SRA:  r = XLEN'($signed(a) >>> sh);
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLT:  r = XLEN'($signed(a) < $signed(b));
            OP_SLTU: r = XLEN'(a < b);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic branch_taken(input logic [2:0] bc,
                                          input logic [XLEN-1:0] a,
                                          input logic [XLEN-1:0] b);
        logic t;
        case (bc)
            BR_BEQ:  t = (a == b);
            BR_BNE:  t = (a != b);
            BR_BLT:  t = ($signed(a) <  $signed(b));
            BR_BGE:  t = ($signed(a) >= $signed(b));
            BR_BLTU: t = (a <  b);
            BR_BGEU: t = (a >= b);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // One shift-add partial product per RUN cycle on operand magnitudes.
    always_comb begin
        mul_sum  = work_q[WW-1:XLEN] + (work_q[0] ? {1'b0, mcand_q} : '0);
        mul_step = {1'b0, mul_sum, work_q[XLEN-1:1]};
    end

`ifdef ALU_MDU_DIV_EN
    logic [XLEN:0]   div_shift;
    logic [XLEN:0]   div_diff;
    logic [WW-1:0]   div_step;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    // One restoring-division quotient bit per RUN cycle on magnitudes.
    always_comb begin
        div_shift = {work_q[2*XLEN-1:XLEN], work_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mcand_q};
        if (div_diff[XLEN]) begin
            div_step = {div_shift, work_q[XLEN-2:0], 1'b0};
        end else begin
            div_step = {div_diff, work_q[XLEN-2:0], 1'b1};
        end
        quo = div_step[XLEN-1:0];
        rem = div_step[2*XLEN-1:XLEN];
    end

    assign run_step = ctrl_q[2] ? div_step : mul_step;
`else
    assign run_step = mul_step;
`endif

    // Final MDU result with sign correction, taken from the last iteration.
    always_comb begin
        prod = mul_step[2*XLEN-1:0];
        if (neg_q) begin
            prod = -prod;
        end
        mdu_res = '0;
        case (ctrl_q)
            OP_MUL:                       mdu_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: mdu_res = prod[2*XLEN-1:XLEN];
`ifdef ALU_MDU_DIV_EN
            OP_DIV:  mdu_res = (b_q == '0) ? '1 : (neg_q ? -quo : quo);
            OP_DIVU: mdu_res = (b_q == '0) ? '1 : quo;
            OP_REM:  mdu_res = (b_q == '0) ? a_q : (a_q[XLEN-1] ? -rem : rem);
            OP_REMU: mdu_res = (b_q == '0) ? a_q : rem;
`endif
            default: mdu_res = '0;
        endcase
    end

    // Operand signedness and magnitudes for an incoming MDU request.
    always_comb begin
        sign_a = (bus.CTRL == OP_MULH) || (bus.CTRL == OP_MULHSU);
        sign_b = (bus.CTRL == OP_MULH);
`ifdef ALU_MDU_DIV_EN
        if ((bus.CTRL == OP_DIV) || (bus.CTRL == OP_REM)) begin
            sign_a = 1'b1;
            sign_b = 1'b1;
        end
`endif
        a_neg = sign_a && bus.A[XLEN-1];
        b_neg = sign_b && bus.B[XLEN-1];
        mag_a = a_neg ? -bus.A : bus.A;
        mag_b = b_neg ? -bus.B : bus.B;
    end

    // Next-state, capture and result logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        ctrl_d  = ctrl_q;
        bc_d    = bc_q;
        mcand_d = mcand_q;
        work_d  = work_q;
        neg_d   = neg_q;
        out_d   = out_q;
        bflag_d = bflag_q;
        ill_d   = ill_q;

        accept    = bus.START && (state_q != S_RUN);
        req_legal = op_legal(bus.CTRL);
        req_mdu   = req_legal && bus.CTRL[4];

        case (state_q)
            S_RUN: begin
                cnt_d  = cnt_q + CW'(1);
                work_d = run_step;
                if (cnt_q == CW'(XLEN - 1)) begin
                    state_d = S_FIN;
                    out_d   = mdu_res;
                    bflag_d = branch_taken(bc_q, a_q, b_q);
                    ill_d   = 1'b0;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            a_d    = bus.A;
            b_d    = bus.B;
            ctrl_d = bus.CTRL;
            bc_d   = bus.BRANCHCONDITION;
            if (req_mdu) begin
                state_d = S_RUN;
                cnt_d   = '0;
                work_d  = {(XLEN + 1)'(0), mag_a};
                mcand_d = mag_b;
                neg_d   = a_neg ^ b_neg;
            end else begin
                state_d = S_FIN;
                out_d   = req_legal ? base_result(bus.CTRL, bus.A, bus.B) : '0;
                bflag_d = branch_taken(bus.BRANCHCONDITION, bus.A, bus.B);
                ill_d   = !req_legal;
            end
        end

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_FIN);
    end

    // State and datapath registers.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            bc_q    <= '0;
            mcand_q <= '0;
            work_q  <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            bflag_q <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            bc_q    <= bc_d;
            mcand_q <= mcand_d;
            work_q  <= work_d;
            neg_q   <= neg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            bflag_q <= bflag_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.BUSY       = busy_q;
    assign bus.DONE       = done_q;
    assign bus.OUT        = out_q;
    assign bus.BRANCHFLAG = bflag_q;
    assign bus.ILLEGAL    = ill_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (XLEN=32) against a plain-arithmetic model.
module tb_alu_mdu;
    localparam int unsigned XLEN = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    alu_mdu_if #(.XLEN(XLEN)) bus ();

    alu_mdu #(.XLEN(XLEN)) dut (
        .CLK    (clk),
        .RESETN (rst_n),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  c;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  bc;
        logic [31:0] eo;
        logic        eb;
        logic        ei;
        int          el;
    } vec_t;

    // Reference behaviour computed directly from the operation definitions.
    function automatic void model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] bc, output logic [31:0] r, output logic bf,
                                  output logic ill, output int lat);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic               mdu;
        r = '0; ill = 1'b0; mdu = 1'b0;
        case (c)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << b[4:0];
            5'd3:  r = a >> b[4:0];
            5'd4:  r = 32'($signed(a) >>> b[4:0]);
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = a ^ b;
            5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:  r = (a < b) ? 32'd1 : 32'd0;
            5'd16: begin up = 64'(a) * 64'(b); r = up[31:0]; mdu = 1'b1; end
            5'd17: begin sp = 64'($signed(a)) * 64'($signed(b)); r = sp[63:32]; mdu = 1'b1; end
            5'd18: begin sp = 64'($signed(a)) * $signed(64'(b)); r = sp[63:32]; mdu = 1'b1; end
            5'd19: begin up = 64'(a) * 64'(b); r = up[63:32]; mdu = 1'b1; end
`ifdef ALU_MDU_DIV_EN
            5'd20: begin
                mdu = 1'b1;
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'($signed(a) / $signed(b));
            end
            5'd21: begin mdu = 1'b1; r = (b == 0) ? 32'hFFFF_FFFF : a / b; end
            5'd22: begin
                mdu = 1'b1;
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
                else r = 32'($signed(a) % $signed(b));
            end
            5'd23: begin mdu = 1'b1; r = (b == 0) ? a : a % b; end
`endif
            default: ill = 1'b1;
        endcase
        if (ill) r = '0;
        case (bc)
            3'd0:    bf = (a == b);
            3'd1:    bf = (a != b);
            3'd4:    bf = ($signed(a) <  $signed(b));
            3'd5:    bf = ($signed(a) >= $signed(b));
            3'd6:    bf = (a <  b);
            3'd7:    bf = (a >= b);
            default: bf = 1'b0;
        endcase
        lat = mdu ? 33 : 1;
    endfunction

    // Issue one request (caller is just after a rising edge) and wait for DONE.
    task automatic exec(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] bc, output logic [31:0] o, output logic bf,
                        output logic il, output int lat, output int busy_cyc);
        bus.START = 1'b1; bus.CTRL = c; bus.A = a; bus.B = b; bus.BRANCHCONDITION = bc;
        @(posedge clk); #1;
        bus.START = 1'b0;
        bus.A = $urandom; bus.B = $urandom;
        bus.CTRL = 5'($urandom); bus.BRANCHCONDITION = 3'($urandom);
        lat = 1; busy_cyc = 0;
        while (bus.DONE !== 1'b1 && lat < 200) begin
            if (bus.BUSY === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            lat++;
        end
        o = bus.OUT; bf = bus.BRANCHFLAG; il = bus.ILLEGAL;
    endtask

    task automatic test_reset();
        bus.START = 1'b0; bus.A = '0; bus.B = '0; bus.CTRL = '0; bus.BRANCHCONDITION = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
        n_cmp++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.DONE); end
        n_cmp++; if (bus.OUT !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 0", bus.OUT); end
        n_cmp++; if (bus.BRANCHFLAG !== 1'b0) begin n_fail++; $display("FAIL reset_bflag: got %b want 0", bus.BRANCHFLAG); end
        n_cmp++; if (bus.ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL reset_illegal: got %b want 0", bus.ILLEGAL); end
        // first request on the first rising edge after release
        bus.START = 1'b1; bus.CTRL = 5'd0; bus.A = 32'd1; bus.B = 32'd1; bus.BRANCHCONDITION = 3'd0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        n_cmp++; if (bus.DONE !== 1'b1) begin n_fail++; $display("FAIL first_req_done: got %b want 1", bus.DONE); end
        n_cmp++; if (bus.OUT !== 32'd2) begin n_fail++; $display("FAIL first_req_out: got %h want 2", bus.OUT); end
        n_cmp++; if (bus.BRANCHFLAG !== 1'b1) begin n_fail++; $display("FAIL first_req_bflag: got %b want 1", bus.BRANCHFLAG); end
    endtask

    task automatic test_directed();
        vec_t v[$];
        logic [31:0] o; logic bf, il; int lat, bsy;
        v.push_back('{5'd0,  32'h7FFF_FFFF, 32'h1,         3'd0, 32'h8000_0000, 1'b0, 1'b0, 1});
        v.push_back('{5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd0, 32'hFFFF_FFFE, 1'b1, 1'b0, 33});
        v.push_back('{5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'h0000_0001, 1'b0, 1'b0, 33});
        v.push_back('{5'd5,  32'hFFFF_FFFF, 32'h1,         3'd4, 32'h0000_0001, 1'b1, 1'b0, 1});
        v.push_back('{5'd5,  32'hFFFF_FFFF, 32'h1,         3'd6, 32'h0000_0001, 1'b0, 1'b0, 1});
        v.push_back('{5'd1,  32'h5,         32'h5,         3'd0, 32'h0,         1'b1, 1'b0, 1});
        v.push_back('{5'd10, 32'h3,         32'h3,         3'd5, 32'h0,         1'b1, 1'b1, 1});
        v.push_back('{5'd4,  32'h8000_0000, 32'h24,        3'd2, 32'hF800_0000, 1'b0, 1'b0, 1});
        v.push_back('{5'd8,  32'hFFFF_FFFF, 32'h1,         3'd7, 32'h1,         1'b1, 1'b0, 1});
`ifdef ALU_MDU_DIV_EN
        v.push_back('{5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 3'd0, 32'h8000_0000, 1'b0, 1'b0, 33});
        v.push_back('{5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 32'h0,         1'b1, 1'b0, 33});
        v.push_back('{5'd21, 32'h7,         32'h0,         3'd1, 32'hFFFF_FFFF, 1'b1, 1'b0, 33});
        v.push_back('{5'd22, 32'hFFFF_FFF9, 32'h2,         3'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, 33});
`else
        v.push_back('{5'd21, 32'd10,        32'd3,         3'd7, 32'h0,         1'b1, 1'b1, 1});
`endif
        foreach (v[i]) begin
            exec(v[i].c, v[i].a, v[i].b, v[i].bc, o, bf, il, lat, bsy);
            n_cmp++; if (o !== v[i].eo) begin n_fail++; $display("FAIL dir%0d_out: got %h want %h", i, o, v[i].eo); end
            n_cmp++; if (bf !== v[i].eb) begin n_fail++; $display("FAIL dir%0d_bflag: got %b want %b", i, bf, v[i].eb); end
            n_cmp++; if (il !== v[i].ei) begin n_fail++; $display("FAIL dir%0d_illegal: got %b want %b", i, il, v[i].ei); end
            n_cmp++; if (lat != v[i].el) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, v[i].el); end
            n_cmp++; if (bsy != v[i].el - 1) begin n_fail++; $display("FAIL dir%0d_busy: got %0d want %0d", i, bsy, v[i].el - 1); end
        end
    endtask

    task automatic test_random();
        logic [4:0] c; logic [31:0] a, b, eo, o; logic [2:0] bc; logic eb, ei, bf, il;
        int el, lat, bsy, sel;
        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 4)      c = 5'($urandom_range(0, 9));
            else if (sel < 8) c = 5'($urandom_range(16, 23));
            else              c = 5'($urandom);
            a = $urandom; b = $urandom; bc = 3'($urandom);
            sel = $urandom_range(0, 7);
            if (sel == 0) b = '0;
            if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (sel == 2) begin a = 32'($urandom_range(0, 20)) - 32'd10; b = 32'($urandom_range(0, 8)) - 32'd4; end
            if (sel == 3) b = a;
            model(c, a, b, bc, eo, eb, ei, el);
            exec(c, a, b, bc, o, bf, il, lat, bsy);
            n_cmp++; if (o !== eo) begin n_fail++; $display("FAIL rnd%0d_out ctrl=%h a=%h b=%h: got %h want %h", i, c, a, b, o, eo); end
            n_cmp++; if (bf !== eb) begin n_fail++; $display("FAIL rnd%0d_bflag bc=%0d: got %b want %b", i, bc, bf, eb); end
            n_cmp++; if (il !== ei) begin n_fail++; $display("FAIL rnd%0d_illegal ctrl=%h: got %b want %b", i, c, il, ei); end
            n_cmp++; if (lat != el) begin n_fail++; $display("FAIL rnd%0d_latency ctrl=%h: got %0d want %0d", i, c, lat, el); end
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] a, b, eo; logic eb, ei; int el, lat, bsy, extra;
        a = $urandom; b = $urandom;
        model(5'd17, a, b, 3'd4, eo, eb, ei, el);
        bus.START = 1'b1; bus.CTRL = 5'd17; bus.A = a; bus.B = b; bus.BRANCHCONDITION = 3'd4;
        @(posedge clk); #1;
        bus.START = 1'b0;
        lat = 1; bsy = 0;
        while (bus.DONE !== 1'b1 && lat < 200) begin
            if (bus.BUSY === 1'b1) bsy++;
            if (lat == 5) begin
                bus.START = 1'b1; bus.CTRL = 5'd0; bus.A = ~a; bus.B = ~b; bus.BRANCHCONDITION = 3'd0;
            end else begin
                bus.START = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        bus.START = 1'b0;
        n_cmp++; if (bus.OUT !== eo) begin n_fail++; $display("FAIL ignore_out: got %h want %h", bus.OUT, eo); end
        n_cmp++; if (bus.BRANCHFLAG !== eb) begin n_fail++; $display("FAIL ignore_bflag: got %b want %b", bus.BRANCHFLAG, eb); end
        n_cmp++; if (lat != 33) begin n_fail++; $display("FAIL ignore_latency: got %0d want 33", lat); end
        n_cmp++; if (bsy != 32) begin n_fail++; $display("FAIL ignore_busy: got %0d want 32", bsy); end
        extra = 0;
        repeat (5) begin @(posedge clk); #1; if (bus.DONE === 1'b1) extra++; end
        n_cmp++; if (extra != 0) begin n_fail++; $display("FAIL ignore_no_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_reset_run();
        logic [31:0] o; logic bf, il; int lat, bsy, dones;
        bus.START = 1'b1; bus.CTRL = 5'd16; bus.A = $urandom | 32'h1; bus.B = $urandom | 32'h1; bus.BRANCHCONDITION = 3'd1;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (3) @(posedge clk); #1;
        bus.START = 1'b1; bus.CTRL = 5'd0; bus.A = 32'd2; bus.B = 32'd3;
        @(posedge clk); #1;
        bus.START = 1'b0;
        repeat (5) @(posedge clk); #1;
        n_cmp++; if (bus.BUSY !== 1'b1) begin n_fail++; $display("FAIL rstrun_busy_before: got %b want 1", bus.BUSY); end
        rst_n = 1'b0; #1;
        n_cmp++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL rstrun_busy: got %b want 0", bus.BUSY); end
        n_cmp++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL rstrun_done: got %b want 0", bus.DONE); end
        n_cmp++; if (bus.OUT !== 32'h0) begin n_fail++; $display("FAIL rstrun_out: got %h want 0", bus.OUT); end
        n_cmp++; if (bus.BRANCHFLAG !== 1'b0) begin n_fail++; $display("FAIL rstrun_bflag: got %b want 0", bus.BRANCHFLAG); end
        n_cmp++; if (bus.ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL rstrun_illegal: got %b want 0", bus.ILLEGAL); end
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        repeat (40) begin @(posedge clk); #1; if (bus.DONE === 1'b1) dones++; end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rstrun_stale_done: got %0d want 0", dones); end
        exec(5'd0, 32'd2, 32'd3, 3'd0, o, bf, il, lat, bsy);
        n_cmp++; if (o !== 32'd5) begin n_fail++; $display("FAIL rstrun_add_out: got %h want 5", o); end
        n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL rstrun_add_latency: got %0d want 1", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] o, eo, a, b; logic bf, il, eb, ei; int lat, bsy, el;
        logic [4:0] first_ops [2];
        first_ops[0] = 5'd21;
        first_ops[1] = 5'd16;
        foreach (first_ops[k]) begin
            model(first_ops[k], 32'd10, 32'd3, 3'd7, eo, eb, ei, el);
            exec(first_ops[k], 32'd10, 32'd3, 3'd7, o, bf, il, lat, bsy);
            n_cmp++; if (o !== eo) begin n_fail++; $display("FAIL b2b%0d_first_out: got %h want %h", k, o, eo); end
            n_cmp++; if (il !== ei) begin n_fail++; $display("FAIL b2b%0d_first_illegal: got %b want %b", k, il, ei); end
            n_cmp++; if (lat != el) begin n_fail++; $display("FAIL b2b%0d_first_latency: got %0d want %0d", k, lat, el); end
            a = $urandom; b = $urandom;
            bus.START = 1'b1; bus.CTRL = 5'd0; bus.A = a; bus.B = b; bus.BRANCHCONDITION = 3'd1;
            @(posedge clk); #1;
            bus.START = 1'b0;
            n_cmp++; if (bus.DONE !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_second_done: got %b want 1", k, bus.DONE); end
            n_cmp++; if (bus.OUT !== a + b) begin n_fail++; $display("FAIL b2b%0d_second_out: got %h want %h", k, bus.OUT, a + b); end
            n_cmp++; if (bus.ILLEGAL !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_second_illegal: got %b want 0", k, bus.ILLEGAL); end
            @(posedge clk); #1;
            n_cmp++; if (bus.DONE !== 1'b0) begin n_fail++; $display("FAIL b2b%0d_idle_done: got %b want 0", k, bus.DONE); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_busy_ignore();
        test_reset_run();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (legal: 8, 16, 32, 64).
REQ-002 SHALL have parameter SHW, default $clog2(XLEN), shift-amount width taken from B[SHW-1:0].
REQ-003 CLK  input  1  single clock, all state on rising edge.
REQ-004 RESETN  input  1  asynchronous, active-low reset.
REQ-005 START  input  1  request strobe; sampled only when BUSY=0.
REQ-006 A, B  input  XLEN each  operands.
REQ-007 CTRL  input  5  op: 00000 ADD, 00001 SUB, 00010 SLL, 00011 SRL, 00100 SRA, 00101 AND, 00110 OR, 00111 XOR, 01000 SLT, 01001 SLTU, 10000 MUL, 10001 MULH, 10010 MULHSU, 10011 MULHU, 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; others illegal.
REQ-008 BRANCHCONDITION  input  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; others give BRANCHFLAG=0.
REQ-009 BUSY  output  1  iterative op in progress.
REQ-010 DONE  output  1  one-cycle result strobe.
REQ-011 OUT  output  XLEN  registered result.
REQ-012 BRANCHFLAG  output  1  registered branch decision for the accepted request (1 = taken).
REQ-013 ILLEGAL  output  1  registered, valid with DONE; 1 for undefined CTRL.

Function
REQ-014 FSM states IDLE, RUN, FIN; BUSY=1 only in RUN.
REQ-015 Request accepted on an edge where START=1 and state is IDLE or FIN; A, B, CTRL, BRANCHCONDITION captured at that edge.
REQ-016 Base ops (CTRL[4]=0) and illegal ops: go to FIN; DONE=1 next cycle (latency 1).
REQ-017 MUL*/DIV*/REM* ops: go to RUN for exactly XLEN cycles, then FIN; DONE=1 XLEN+1 cycles after acceptance.
REQ-018 DONE=1 exactly in FIN; FIN returns to IDLE unless a new request is accepted the same edge (back-to-back allowed, no bubble).
REQ-019 START while BUSY=1 SHALL be ignored (no queuing, captured operands unchanged).
REQ-020 OUT, BRANCHFLAG, ILLEGAL update only on entry to FIN and hold until next FIN.
REQ-021 Shifts use B[SHW-1:0]; SRA sign-fills; SLT signed, SLTU unsigned; result 0/1 zero-extended.
REQ-022 Multiply: shift-add, one partial product per RUN cycle, 2*XLEN-bit product; MUL low half, MULH/MULHSU/MULHU high half with signed*signed, signed*unsigned, unsigned*unsigned.
REQ-023 Divide: restoring, one quotient bit per RUN cycle on magnitudes, sign-corrected in FIN entry; quotient truncates toward zero, remainder takes dividend sign.
REQ-024 B=0: DIV/DIVU = all ones, REM/REMU = A.
REQ-025 Signed overflow (A=most-negative, B=-1): DIV = A, REM = 0.
REQ-026 Branch: BEQ A==B, BNE A!=B, BLT/BGE signed, BLTU/BGEU unsigned; computed from captured A, B independent of CTRL.
REQ-027 Illegal CTRL: OUT=0, BRANCHFLAG per REQ-026, ILLEGAL=1.

Reset
REQ-028 RESETN=0 SHALL immediately force state IDLE, BUSY=0, DONE=0, OUT=0, BRANCHFLAG=0, ILLEGAL=0, iteration counter 0.
REQ-029 Reset during RUN SHALL abort the op; no DONE for it after reset release.
REQ-030 First request accepted on the first rising edge with RESETN=1 and START=1.

Configuration
REQ-031 Macro ALU_MDU_DIV_EN: defined -> DIV/DIVU/REM/REMU per REQ-017, REQ-023..025.
REQ-032 Not defined -> divider logic absent; DIV/DIVU/REM/REMU treated as illegal (latency 1, OUT=0, ILLEGAL=1); MUL* unaffected.

Verification
REQ-033 XLEN=32: ADD A=0x7FFFFFFF B=1 -> DONE next cycle, OUT=0x80000000, ILLEGAL=0.
REQ-034 MULHU A=B=0xFFFFFFFF -> BUSY 32 cycles, DONE 33 cycles after accept, OUT=0xFFFFFFFE; MUL same operands -> OUT=0x00000001.
REQ-035 DIV A=0x80000000 B=0xFFFFFFFF -> OUT=0x80000000; REM same -> 0; DIVU A=7 B=0 -> 0xFFFFFFFF; REM A=-7 B=2 -> 0xFFFFFFFF.
REQ-036 BLT A=0xFFFFFFFF B=1 -> BRANCHFLAG=1; BLTU same -> 0; BEQ A=B=5 -> 1.
REQ-037 MUL accepted, START pulsed mid-RUN with ADD, RESETN low at RUN cycle 10 -> all outputs 0, no DONE; next ADD 2+3 -> OUT=5 latency 1.
REQ-038 Build without ALU_MDU_DIV_EN: DIVU A=10 B=3 -> DONE latency 1, OUT=0, ILLEGAL=1; back-to-back ADD accepted in FIN -> DONE on consecutive cycles.
